// File: rtl/vn_pipe.sv
// vn_pipe: 4-stage LDPC variable node (DV sign-magnitude c2v in, DV extrinsic v2c out, hard decision).
// Define VN_PIPE_APP_OUT_EN to add the saturated APP output o_app_llr.
module vn_pipe #(
  parameter int MSG_WIDTH = 6,
  parameter int DV = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic                    i_init,
  input  logic [MSG_WIDTH-1:0]    i_llr,
  input  logic [MSG_WIDTH*DV-1:0] i_c2v_bus,
  output logic                    o_valid,
  output logic                    o_app,
  output logic [MSG_WIDTH*DV-1:0] o_v2c_bus
`ifdef VN_PIPE_APP_OUT_EN
  ,
  output logic [MSG_WIDTH-1:0]    o_app_llr
`endif
);
  localparam int SUM_W = MSG_WIDTH + $clog2(DV + 1);
  localparam int HALF = (DV + 1) / 2;
  localparam int POS_MAX = 2 ** (MSG_WIDTH - 1) - 1;
  typedef logic signed [MSG_WIDTH-1:0] msg_t;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic signed [SUM_W:0] dif_t;
  logic v1_q, v2_q, v3_q, v4_q;
  msg_t llr_q;
  msg_t c2v1_d [DV];
  msg_t c2v1_q [DV];
  msg_t c2v2_q [DV];
  msg_t c2v3_q [DV];
  sum_t a_d, b_d, a_q, b_q, tot_q;
  dif_t dif [DV];
  msg_t sat [DV];
  msg_t mag [DV];
  logic [MSG_WIDTH*DV-1:0] v2c_d, v2c_q;
  logic app_q;

  // Symmetric clamp keeps -2^(W-1) out of the result so sign-magnitude stays representable
  function automatic msg_t sat_f(input dif_t x);
    return x > dif_t'(POS_MAX) ? msg_t'(POS_MAX) : x < -dif_t'(POS_MAX) ? msg_t'(-POS_MAX) : msg_t'(x);
  endfunction

  always_comb begin
    for (int k = 0; k < DV; k++)
      c2v1_d[k] = i_init ? '0 :
                  i_c2v_bus[MSG_WIDTH*(k+1)-1] ? msg_t'(-{1'b0, i_c2v_bus[MSG_WIDTH*k +: MSG_WIDTH-1]}) :
                  msg_t'({1'b0, i_c2v_bus[MSG_WIDTH*k +: MSG_WIDTH-1]});
  end

  always_comb begin
    a_d = sum_t'(llr_q);
    b_d = '0;
    for (int k = 0; k < DV; k++) begin
      if (k < HALF) a_d = a_d + sum_t'(c2v1_q[k]);
      else b_d = b_d + sum_t'(c2v1_q[k]);
    end
  end

  always_comb begin
    v2c_d = '0;
    for (int k = 0; k < DV; k++) begin
      dif[k] = dif_t'(tot_q) - dif_t'(c2v3_q[k]);
      sat[k] = sat_f(dif[k]);
      mag[k] = sat[k] < 0 ? -sat[k] : sat[k];
      v2c_d[MSG_WIDTH*k +: MSG_WIDTH] = {sat[k][MSG_WIDTH-1], mag[k][MSG_WIDTH-2:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {v1_q, v2_q, v3_q, v4_q} <= '0;
      llr_q <= '0;
      c2v1_q <= '{default: '0};
      c2v2_q <= '{default: '0};
      c2v3_q <= '{default: '0};
      a_q <= '0;
      b_q <= '0;
      tot_q <= '0;
      v2c_q <= '0;
      app_q <= 1'b0;
    end else begin
      v1_q <= i_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
      llr_q <= i_llr;
      c2v1_q <= c2v1_d;
      c2v2_q <= c2v1_q;
      c2v3_q <= c2v2_q;
      a_q <= a_d;
      b_q <= b_d;
      tot_q <= a_q + b_q;
      if (v3_q) begin
        v2c_q <= v2c_d;
        app_q <= tot_q[SUM_W-1];
      end
    end
  end

`ifdef VN_PIPE_APP_OUT_EN
  msg_t app_llr_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) app_llr_q <= '0;
    else if (v3_q) app_llr_q <= sat_f(dif_t'(tot_q));
  end
  assign o_app_llr = app_llr_q;
`endif

  assign o_valid = v4_q;
  assign o_app = app_q;
  assign o_v2c_bus = v2c_q;
endmodule

// File: tb/tb_vn_pipe.sv
// tb_vn_pipe: directed and random-throughput checks of vn_pipe at MSG_WIDTH=6, DV=6.
module tb_vn_pipe;
  logic clk = 1'b0;
  logic rst, valid, init;
  logic [5:0] llr;
  logic [35:0] c2v;
  logic o_valid, o_app;
  logic [35:0] o_v2c;
  int tests = 0;
  int fails = 0;
  logic [5:0] ql [20];
  logic [35:0] qb [20];
  logic qi [20];
  logic [35:0] eb;
  logic ea;
  logic [5:0] el;
`ifdef VN_PIPE_APP_OUT_EN
  logic [5:0] o_app_llr;
`endif

  always #5 clk = ~clk;

  vn_pipe #(.MSG_WIDTH(6), .DV(6)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid(valid),
    .i_init(init),
    .i_llr(llr),
    .i_c2v_bus(c2v),
    .o_valid(o_valid),
    .o_app(o_app),
    .o_v2c_bus(o_v2c)
`ifdef VN_PIPE_APP_OUT_EN
    ,
    .o_app_llr(o_app_llr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [5:0] l, input logic [35:0] b, input logic n);
    @(negedge clk);
    valid = 1'b1;
    llr = l;
    c2v = b;
    init = n;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("early", o_valid, 0);
    @(negedge clk);
    chk("valid", o_valid, 1);
  endtask

  task automatic app_llr_chk(input string tag, input logic [5:0] exp);
`ifdef VN_PIPE_APP_OUT_EN
    chk(tag, o_app_llr, exp);
`endif
  endtask

  function automatic void model(input logic [5:0] l, input logic [35:0] b, input logic n,
                                output logic [35:0] v, output logic a, output logic [5:0] al);
    int c [6];
    int tot;
    int d;
    tot = $signed(l);
    for (int k = 0; k < 6; k++) begin
      c[k] = n ? 0 : b[6*k+5] ? -int'(b[6*k +: 5]) : int'(b[6*k +: 5]);
      tot += c[k];
    end
    v = '0;
    for (int k = 0; k < 6; k++) begin
      d = tot - c[k];
      d = d > 31 ? 31 : d < -31 ? -31 : d;
      v[6*k +: 6] = d < 0 ? {1'b1, 5'(-d)} : {1'b0, 5'(d)};
    end
    a = tot < 0;
    d = tot > 31 ? 31 : tot < -31 ? -31 : tot;
    al = 6'(d);
  endfunction

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    init = 1'b0;
    llr = '0;
    c2v = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_bus", o_v2c, 0);
    chk("rst_app", o_app, 0);
    rst = 1'b0;
    apply(6'b000101, {6{6'b000011}}, 1'b0);
    chk("basic_bus", o_v2c, {6{6'b010100}});
    chk("basic_app", o_app, 0);
    app_llr_chk("basic_app_llr", 6'b010111);
    apply(6'b110110, {6{6'b100010}}, 1'b0);
    chk("neg_bus", o_v2c, {6{6'b110100}});
    chk("neg_app", o_app, 1);
    app_llr_chk("neg_app_llr", 6'b101010);
    @(negedge clk);
    chk("hold_valid", o_valid, 0);
    chk("hold_bus", o_v2c, {6{6'b110100}});
    chk("hold_app", o_app, 1);
    apply(6'b011111, {6{6'b011111}}, 1'b0);
    chk("satp_bus", o_v2c, {6{6'b011111}});
    chk("satp_app", o_app, 0);
    app_llr_chk("satp_app_llr", 6'b011111);
    apply(6'b100001, {6{6'b111111}}, 1'b0);
    chk("satn_bus", o_v2c, {6{6'b111111}});
    chk("satn_app", o_app, 1);
    app_llr_chk("satn_app_llr", 6'b100001);
    apply(6'b000100, {6'b100001, 6'b000001, 6'b100000, 6'b000000, 6'b100100, 6'b000100}, 1'b0);
    chk("mixed_bus", o_v2c, {6'b000101, 6'b000011, 6'b000100, 6'b000100, 6'b001000, 6'b000000});
    chk("mixed_app", o_app, 0);
    app_llr_chk("mixed_app_llr", 6'b000100);
    apply(6'b000100, {6'b100001, 6'b000001, 6'b100000, 6'b000000, 6'b100100, 6'b000100}, 1'b1);
    chk("init_bus", o_v2c, {6{6'b000100}});
    chk("init_app", o_app, 0);
    app_llr_chk("init_app_llr", 6'b000100);
    apply(6'b111101, 36'h000000003, 1'b0);
    chk("zero_bus", o_v2c, 36'h000000023);
    chk("zero_app", o_app, 0);
    app_llr_chk("zero_app_llr", 6'b000000);
    for (int i = 0; i < 20; i++) begin
      ql[i] = 6'($urandom);
      qb[i] = 36'({$urandom, $urandom});
      qi[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        model(ql[i-4], qb[i-4], qi[i-4], eb, ea, el);
        chk("tp_valid", o_valid, 1);
        chk("tp_bus", o_v2c, eb);
        chk("tp_app", o_app, ea);
        app_llr_chk("tp_app_llr", el);
      end else chk("tp_idle", o_valid, 0);
      valid = i < 20;
      if (i < 20) begin
        llr = ql[i];
        c2v = qb[i];
        init = qi[i];
      end
    end
    @(negedge clk);
    chk("tp_end", o_valid, 0);
    apply(6'b000101, {6{6'b000011}}, 1'b0);
    chk("pre_rst_bus", o_v2c, {6{6'b010100}});
    @(negedge clk);
    valid = 1'b1;
    init = 1'b0;
    llr = 6'b000101;
    c2v = {6{6'b000011}};
    @(negedge clk);
    llr = 6'b110110;
    @(negedge clk);
    llr = 6'b011111;
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_bus", o_v2c, 0);
    chk("mid_rst_app", o_app, 0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_valid", o_valid, 0);
      @(negedge clk);
    end
    chk("mid_rst_hold", o_v2c, 0);
    apply(6'b110110, {6{6'b100010}}, 1'b0);
    chk("post_rst_bus", o_v2c, {6{6'b110100}});
    chk("post_rst_app", o_app, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vn_pipe.md
Name: vn_pipe

Overview:
- Parametrised LDPC variable-node processor for the column-layered decoder; successor to the fixed degree-6 variable node.
- Each accepted vector carries one channel LLR and DV check-to-variable (c2v) messages. The block returns DV extrinsic variable-to-check (v2c) messages and a hard decision.
- Adds: generic degree DV, valid pipeline, sign-magnitude c2v input, init mode for iteration 0, protection against negative zero.
- One instance per column slot, between the c2v routing network and the check-node array.

Parameters:
- MSG_WIDTH, 6, bit width of LLR and of each c2v/v2c message.
- DV, 6, variable-node degree (number of edges), 2..16.
- SUM_W, MSG_WIDTH+$clog2(DV+1), internal signed accumulator width (localparam, not overridable).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  input vector valid.
- i_init  in  1  first iteration: ignore c2v and treat all as 0. Sampled with i_valid.
- i_llr  in  MSG_WIDTH  channel LLR, two's complement.
- i_c2v_bus  in  MSG_WIDTH*DV  c2v messages, sign-magnitude. Edge k occupies [MSG_WIDTH*(k+1)-1 : MSG_WIDTH*k].
- o_valid  out  1  output vector valid.
- o_app  out  1  hard decision, the sign of the APP sum (1 = negative).
- o_v2c_bus  out  MSG_WIDTH*DV  extrinsic messages, sign-magnitude, same packing as the input.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- During reset, all pipeline valids and all outputs go to 0: o_valid=0, o_app=0, o_v2c_bus=0. Data registers without valids may also be cleared.
- No backpressure. One vector may be accepted per cycle, back-to-back.
- Fixed latency: o_valid is asserted exactly 4 cycles after i_valid. Outputs hold their last value while o_valid=0.
- Pipeline:
  - S1: register i_llr. Convert each c2v from sign-magnitude to two's complement: {1, mag} -> -mag. If i_init=1, force every c2v to 0. Register the valid.
  - S2: partial sum A = llr + c2v[0 .. ceil(DV/2)-1]; partial sum B = remaining c2v. Both SUM_W wide. Delay the converted c2v by one stage.
  - S3: total = A + B, SUM_W wide, no overflow possible. Delay the c2v again.
  - S4: for each edge k, diff_k = total - c2v[k] at SUM_W+1 width. Saturate symmetrically to ±POS_MAX, where POS_MAX = 2^(MSG_WIDTH-1)-1. Convert to sign-magnitude and register. o_app = sign(total), registered.
- Negative-zero input (sign=1, mag=0) is treated as 0.
- Output never contains negative zero. -POS_MAX..-1 maps to sign=1 with magnitude 1..POS_MAX; zero maps to all-zeros.
- total = 0 gives o_app = 0.
- Reset mid-stream: vectors in flight are discarded, and no o_valid pulse appears after reset deasserts unless new i_valid arrives.
- i_valid=0 cycles: data registers may toggle freely, but o_valid stays 0.

Optional Feature:
- Macro VN_PIPE_APP_OUT_EN.
- Defined:
  - Adds output port o_app_llr [MSG_WIDTH-1:0], two's complement.
  - Value is total saturated to ±POS_MAX, registered in S4 and aligned with o_valid. Reset value 0.
  - Used by the early-termination and soft-output logic.
- Undefined:
  - Port absent, no extra registers.
  - All other behaviour is identical.

Test Plan:
- Basic sum. MSG_WIDTH=6, DV=6; llr=+5, all c2v=000011 (+3), i_init=0. Expect o_valid 4 cycles later, every v2c=010100 (+20), o_app=0.
- Negative. llr=-10, all c2v=100010 (-2). Total is -22, so every v2c=110100 (-20), o_app=1.
- Saturation. llr=+31, all c2v=011111. Total 217, so every v2c=011111; also llr=-31 with all c2v=111111 gives every v2c=111111. With VN_PIPE_APP_OUT_EN, o_app_llr=+31 and -31 respectively.
- Mixed signs and init.
  - llr=+4, c2v=(+4,-4,0,100000,+1,-1). Total 4, so v2c=(0,+8,+4,+4,+3,+5); negative-zero input gives +4, not negative-zero output.
  - Same vector with i_init=1: all v2c=000100, o_app=0.
- Throughput. 20 back-to-back random vectors with random i_init. o_valid is high for 20 consecutive cycles starting 4 cycles after the first input. Every output matches the reference model in order.
- Reset. Drive 3 back-to-back vectors, assert i_rst for 1 cycle while they are in flight, then hold i_valid=0. No o_valid follows, and outputs read 0 from the cycle after reset. Next vector returns with latency 4.
